// File: rtl/i2c_target_regs_pkg.sv
// Shared definitions for the I2C target register block.
package i2c_target_regs_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  // Level seen on SDA during the acknowledge bit
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK
  } state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Pad synchronizer plus glitch filter with registered rise/fall strobes.
module i2c_line_filter #(
  parameter int unsigned FILTER_CK = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILTER_CK + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer; idle bus level is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], pad};
  end

  // Accept a new level only after FILTER_CK consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == CW'(FILTER_CK - 1)) begin
          level <= sync[1];
          cnt   <= '0;
          rise  <= sync[1];
          fall  <= ~sync[1];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target serving a byte-wide register file with pointer-then-data access.
module i2c_target_regs
  import i2c_target_regs_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDR  = 7'h50,
  parameter int unsigned AW        = 4,
  parameter int unsigned FILTER_CK = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_scl,
  input  logic          i_sda,
  output logic          o_sda_ld,
  output logic          o_wr_stb,
  output logic [AW-1:0] o_wr_addr,
  output logic [7:0]    o_wr_data,
  input  logic [AW-1:0] i_host_addr,
  output logic [7:0]    o_host_data
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_CK(FILTER_CK)) u_scl_filt (
    .clk(i_clk), .rst(i_rst), .pad(i_scl),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILTER_CK(FILTER_CK)) u_sda_filt (
    .clk(i_clk), .rst(i_rst), .pad(i_sda),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  logic start, stop;
  assign start = sda_fall & scl_lvl;
  assign stop  = sda_rise & scl_lvl;

  state_t               state, state_n;
  logic [BIT_CNT_W-1:0] cnt, cnt_n;
  logic [BYTE_W-1:0]    shift, shift_n;
  logic [AW-1:0]        ptr, ptr_n;
  logic                 rw, rw_n;
  logic                 sda_ld_n, wr_stb_n;
  logic [AW-1:0]        wr_addr_n;
  logic [7:0]           wr_data_n;
  logic                 reg_we;
  logic [BYTE_W-1:0]    byte_in, rd_byte;
  logic [7:0]           regs [DEPTH];

  assign byte_in = {shift[BYTE_W-2:0], sda_lvl};
  assign rd_byte = regs[ptr];

  // FSM, datapath and output register updates
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      shift     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      o_sda_ld  <= 1'b0;
      o_wr_stb  <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shift     <= shift_n;
      ptr       <= ptr_n;
      rw        <= rw_n;
      o_sda_ld  <= sda_ld_n;
      o_wr_stb  <= wr_stb_n;
      o_wr_addr <= wr_addr_n;
      o_wr_data <= wr_data_n;
    end
  end

  // Next-state: START/STOP override, bits on SCL rise, SDA changes on SCL fall
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shift_n   = shift;
    ptr_n     = ptr;
    rw_n      = rw;
    sda_ld_n  = o_sda_ld;
    wr_stb_n  = 1'b0;
    wr_addr_n = o_wr_addr;
    wr_data_n = o_wr_data;
    reg_we    = 1'b0;
    if (start) begin
      state_n  = ST_ADDR;
      cnt_n    = '0;
      sda_ld_n = 1'b0;
    end else if (stop) begin
      state_n  = ST_IDLE;
      cnt_n    = '0;
      sda_ld_n = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_n = byte_in;
            cnt_n   = cnt + BIT_CNT_W'(1);
            if (cnt == BIT_CNT_W'(7)) begin
              if (state == ST_ADDR) begin
                if (byte_in[7:1] == I2C_ADDR) begin
                  state_n = ST_ADDR_ACK;
                  rw_n    = byte_in[0];
                end else begin
                  state_n = ST_IDLE;
                end
              end else if (state == ST_PTR) begin
                ptr_n   = byte_in[AW-1:0];
                state_n = ST_PTR_ACK;
              end else begin
                reg_we    = 1'b1;
                wr_stb_n  = 1'b1;
                wr_addr_n = ptr;
                wr_data_n = byte_in;
                ptr_n     = ptr + AW'(1);
                state_n   = ST_WDATA_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!o_sda_ld) begin
              sda_ld_n = ~I2C_ACK;
            end else if (state == ST_ADDR_ACK && rw) begin
              // Release of the ack is also the first data bit of the read
              sda_ld_n = ~rd_byte[7];
              shift_n  = {rd_byte[BYTE_W-2:0], 1'b0};
              cnt_n    = BIT_CNT_W'(1);
              state_n  = ST_RDATA;
            end else begin
              sda_ld_n = 1'b0;
              state_n  = (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
            end
          end
        end
        ST_RDATA: begin
          if (scl_fall) begin
            if (cnt == '0) begin
              sda_ld_n = 1'b0;
              state_n  = ST_RACK;
            end else begin
              sda_ld_n = ~shift[BYTE_W-1];
              shift_n  = {shift[BYTE_W-2:0], 1'b0};
              cnt_n    = cnt + BIT_CNT_W'(1);
            end
          end
        end
        ST_RACK: begin
          // Entered on a fall, so the rise (controller ack) always comes first
          if (scl_rise) begin
            ptr_n = ptr + AW'(1);
            if (sda_lvl == I2C_NACK) state_n = ST_IDLE;
          end else if (scl_fall) begin
            sda_ld_n = ~rd_byte[7];
            shift_n  = {rd_byte[BYTE_W-2:0], 1'b0};
            cnt_n    = BIT_CNT_W'(1);
            state_n  = ST_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  // Register file; cleared by reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[ptr] <= byte_in;
    end
  end

  // Host read port, one-cycle latency, returns pre-write value on collision
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_host_data <= '0;
    else       o_host_data <= regs[i_host_addr];
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: bit-banged I2C controller against i2c_target_regs.
module tb_i2c_target_regs;

  localparam int Q = 16;  // clocks per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tb_scl = 1'b1;
  logic       tb_sda = 1'b1;
  logic       sda_bus;
  logic       sda_ld;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] host_addr = 4'h0;
  logic [7:0] host_data;

  int n_cmp = 0;
  int n_err = 0;
  int stb_cnt = 0;
  int ld_cnt = 0;
  logic [3:0] stb_addr = 4'h0;
  logic [7:0] stb_data = 8'h00;

  always #5 clk = ~clk;

  // Open-drain SDA: either side may pull low
  assign sda_bus = tb_sda & ~sda_ld;

  i2c_target_regs dut (
    .i_clk(clk), .i_rst(rst), .i_scl(tb_scl), .i_sda(sda_bus),
    .o_sda_ld(sda_ld), .o_wr_stb(wr_stb), .o_wr_addr(wr_addr),
    .o_wr_data(wr_data), .i_host_addr(host_addr), .o_host_data(host_data)
  );

  // Record write strobes and any SDA drive
  always @(negedge clk) begin
    if (wr_stb) begin
      stb_cnt  <= stb_cnt + 1;
      stb_addr <= wr_addr;
      stb_data <= wr_data;
    end
    if (sda_ld) ld_cnt <= ld_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    tb_sda = 1'b1; wait_q();
    tb_scl = 1'b1; wait_q();
    tb_sda = 1'b0; wait_q();
    tb_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    tb_sda = 1'b0; wait_q();
    tb_scl = 1'b1; wait_q();
    tb_sda = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b, input bit glitch);
    tb_sda = b; wait_q();
    tb_scl = 1'b1; wait_q();
    if (glitch) begin
      tb_scl = 1'b0;
      repeat (2) @(negedge clk);
      tb_scl = 1'b1;
    end
    wait_q();
    tb_scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic r);
    tb_sda = 1'b1; wait_q();
    tb_scl = 1'b1; wait_q();
    r = sda_bus;
    wait_q();
    tb_scl = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack, input int glitch_bit);
    for (int i = 7; i >= 0; i--) write_bit(b[i], i == glitch_bit);
    read_bit(ack);
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      read_bit(r);
      d[i] = r;
    end
    write_bit(ack, 1'b0);
  endtask

  task automatic host_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    host_addr = a;
    @(negedge clk);
    d = host_data;
  endtask

  task automatic apply_reset();
    tb_scl = 1'b1;
    tb_sda = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         s0, l0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_sda_ld", 32'(sda_ld), 32'h0);
    check_eq("rst_wr_stb", 32'(wr_stb), 32'h0);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'h0);
    check_eq("rst_wr_data", 32'(wr_data), 32'h0);
    check_eq("rst_host_data", 32'(host_data), 32'h0);
    apply_reset();

    // Write: A0 03 A5 5A
    s0 = stb_cnt;
    i2c_start();
    send_byte(8'hA0, ack, -1); check_eq("wr_addr_ack", 32'(ack), 32'h0);
    send_byte(8'h03, ack, -1); check_eq("wr_ptr_ack", 32'(ack), 32'h0);
    send_byte(8'hA5, ack, -1); check_eq("wr_d0_ack", 32'(ack), 32'h0);
    check_eq("wr_d0_stb_cnt", 32'(stb_cnt - s0), 32'd1);
    check_eq("wr_d0_stb", {20'h0, stb_addr, stb_data}, 32'h3A5);
    send_byte(8'h5A, ack, -1); check_eq("wr_d1_ack", 32'(ack), 32'h0);
    check_eq("wr_d1_stb_cnt", 32'(stb_cnt - s0), 32'd2);
    check_eq("wr_d1_stb", {20'h0, stb_addr, stb_data}, 32'h45A);
    i2c_stop();
    host_rd(4'h3, d); check_eq("host_rd3", 32'(d), 32'hA5);
    host_rd(4'h4, d); check_eq("host_rd4", 32'(d), 32'h5A);

    // Read: A0 03 Sr A1, two bytes then NACK
    i2c_start();
    send_byte(8'hA0, ack, -1); check_eq("rd_addr_ack", 32'(ack), 32'h0);
    send_byte(8'h03, ack, -1); check_eq("rd_ptr_ack", 32'(ack), 32'h0);
    i2c_start();
    send_byte(8'hA1, ack, -1); check_eq("rd_addrr_ack", 32'(ack), 32'h0);
    recv_byte(1'b0, d); check_eq("rd_byte0", 32'(d), 32'hA5);
    recv_byte(1'b1, d); check_eq("rd_byte1", 32'(d), 32'h5A);
    check_eq("rd_released", 32'(sda_ld), 32'h0);
    i2c_stop();
    i2c_start();
    send_byte(8'hA1, ack, -1); check_eq("rd2_addr_ack", 32'(ack), 32'h0);
    recv_byte(1'b1, d); check_eq("rd2_reg5", 32'(d), 32'h00);
    i2c_stop();

    // Address miss
    s0 = stb_cnt;
    l0 = ld_cnt;
    i2c_start();
    send_byte(8'hA2, ack, -1); check_eq("miss_addr_nack", 32'(ack), 32'h1);
    send_byte(8'h03, ack, -1); check_eq("miss_ptr_nack", 32'(ack), 32'h1);
    send_byte(8'h99, ack, -1); check_eq("miss_data_nack", 32'(ack), 32'h1);
    i2c_stop();
    check_eq("miss_no_drive", 32'(ld_cnt - l0), 32'd0);
    check_eq("miss_no_stb", 32'(stb_cnt - s0), 32'd0);
    host_rd(4'h3, d); check_eq("miss_reg3", 32'(d), 32'hA5);

    // Pointer wrap
    i2c_start();
    send_byte(8'hA0, ack, -1);
    send_byte(8'h0F, ack, -1);
    send_byte(8'h11, ack, -1);
    check_eq("wrap_stb0", {20'h0, stb_addr, stb_data}, 32'hF11);
    send_byte(8'h22, ack, -1);
    check_eq("wrap_stb1", {20'h0, stb_addr, stb_data}, 32'h022);
    i2c_stop();
    host_rd(4'hF, d); check_eq("wrap_regF", 32'(d), 32'h11);
    host_rd(4'h0, d); check_eq("wrap_reg0", 32'(d), 32'h22);

    // SCL glitch inside pointer byte must not add a bit
    s0 = stb_cnt;
    i2c_start();
    send_byte(8'hA0, ack, -1);
    send_byte(8'h06, ack, 4); check_eq("glitch_ptr_ack", 32'(ack), 32'h0);
    send_byte(8'h77, ack, 2); check_eq("glitch_data_ack", 32'(ack), 32'h0);
    check_eq("glitch_stb_cnt", 32'(stb_cnt - s0), 32'd1);
    check_eq("glitch_stb", {20'h0, stb_addr, stb_data}, 32'h677);
    i2c_stop();
    host_rd(4'h6, d); check_eq("glitch_reg6", 32'(d), 32'h77);

    // STOP after 4 data bits: no write
    s0 = stb_cnt;
    i2c_start();
    send_byte(8'hA0, ack, -1);
    send_byte(8'h08, ack, -1);
    write_bit(1'b1, 1'b0);
    write_bit(1'b0, 1'b0);
    write_bit(1'b1, 1'b0);
    write_bit(1'b0, 1'b0);
    i2c_stop();
    check_eq("abort_no_stb", 32'(stb_cnt - s0), 32'd0);
    host_rd(4'h8, d); check_eq("abort_reg8", 32'(d), 32'h00);

    // Reset while driving a read bit low
    i2c_start();
    send_byte(8'hA0, ack, -1);
    send_byte(8'h03, ack, -1);
    i2c_start();
    send_byte(8'hA1, ack, -1);
    read_bit(ack); check_eq("rdrst_bit7", 32'(ack), 32'h1);
    check_eq("rdrst_driving", 32'(sda_ld), 32'h1);
    rst = 1'b1;
    #1;
    check_eq("rdrst_release", 32'(sda_ld), 32'h0);
    tb_scl = 1'b1;
    tb_sda = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    host_rd(4'h3, d); check_eq("rdrst_reg3", 32'(d), 32'h00);
    host_rd(4'hF, d); check_eq("rdrst_regF", 32'(d), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
